// File: rtl/rob_state_core_if.sv
// Signal bundle between the ROB control FSM (master) and the ROB storage core (slave).
// Covers the RST, order-queue and temporary-register-file ports.
interface rob_state_core_if;
    logic [4:0]  Rsaddr_rst;
    logic [4:0]  Rstag_rst;
    logic        Rsvalid_rst;
    logic [4:0]  Rtaddr_rst;
    logic [4:0]  Rttag_rst;
    logic        Rtvalid_rst;
    logic [4:0]  Wdata_rst;
    logic [4:0]  Waddr_rst;
    logic        Wen_rst;
    logic        Wen0_rst;
    logic [31:0] Wen1_rst;
    logic [4:0]  RB_tag_rst;
    logic        RB_valid_rst;
    logic [4:0]  inData;
    logic        new_data;
    logic        out_data;
    logic        increment;
    logic [4:0]  outData;
    logic        full;
    logic        empty;
    logic [72:0] Data_In;
    logic [4:0]  Waddr;
    logic        New_entry;
    logic        Update_entry;
    logic [4:0]  Rd_Addr1;
    logic [72:0] Data_out1;
    logic [4:0]  Rd_Addr2;
    logic [72:0] Data_out2;

    modport master (
        output Rsaddr_rst, Rtaddr_rst, Wdata_rst, Waddr_rst, Wen_rst, Wen0_rst,
               RB_tag_rst, RB_valid_rst, inData, new_data, out_data, increment,
               Data_In, Waddr, New_entry, Update_entry, Rd_Addr1, Rd_Addr2,
        input  Rstag_rst, Rsvalid_rst, Rttag_rst, Rtvalid_rst, Wen1_rst,
               outData, full, empty, Data_out1, Data_out2
    );

    modport slave (
        input  Rsaddr_rst, Rtaddr_rst, Wdata_rst, Waddr_rst, Wen_rst, Wen0_rst,
               RB_tag_rst, RB_valid_rst, inData, new_data, out_data, increment,
               Data_In, Waddr, New_entry, Update_entry, Rd_Addr1, Rd_Addr2,
        output Rstag_rst, Rsvalid_rst, Rttag_rst, Rtvalid_rst, Wen1_rst,
               outData, full, empty, Data_out1, Data_out2
    );
endinterface

// File: rtl/rob_state_core.sv
// ROB storage core: register status table, program-order tag queue and temporary
// register file. Reads are combinational; writes land on the rising clock edge.
module rob_state_core #(
    parameter int NREG  = 32,
    parameter int NTAG  = 32,
    parameter int RFT_W = 73
) (
    input  logic           clock,
    input  logic           reset,
    rob_state_core_if.slave bus
);

    logic [4:0]       r_rst_tag   [NREG];
    logic             r_rst_valid [NREG];
    logic [4:0]       r_q_mem     [NTAG];
    logic [4:0]       r_q_wr_ptr;
    logic [4:0]       r_q_rd_ptr;
    logic [5:0]       r_q_count;
    logic [RFT_W-1:0] r_rft       [NTAG];

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_wen1;

    // RST update: flush beats rename write, rename write beats retire-clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rst_tag[i]   <= 5'd0;
                r_rst_valid[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.Wen0_rst) begin
                    r_rst_valid[i] <= 1'b0;
                end else if (bus.Wen_rst && (bus.Waddr_rst == i[4:0])) begin
                    r_rst_tag[i]   <= bus.Wdata_rst;
                    r_rst_valid[i] <= 1'b1;
                end else if (bus.RB_valid_rst && r_rst_valid[i] &&
                             (r_rst_tag[i] == bus.RB_tag_rst)) begin
                    r_rst_valid[i] <= 1'b0;
                end else begin
                    r_rst_valid[i] <= r_rst_valid[i];
                end
            end
        end
    end

    // One-hot decode of the rename write strobe
    always_comb begin
        w_wen1 = 32'd0;
        if (bus.Wen_rst) begin
            w_wen1 = 32'd1 << bus.Waddr_rst;
        end else begin
            w_wen1 = 32'd0;
        end
    end

    assign w_full  = (r_q_count == 6'd32);
    assign w_empty = (r_q_count == 6'd0);
    // A pop never frees room for a same-cycle push; full is judged on current state
    assign w_push  = bus.new_data & ~w_full;
    assign w_pop   = bus.out_data & bus.increment & ~w_empty;

    // Order queue: circular buffer, pointers wrap naturally at 5 bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAG; i++) begin
                r_q_mem[i] <= 5'd0;
            end
            r_q_wr_ptr <= 5'd0;
            r_q_rd_ptr <= 5'd0;
            r_q_count  <= 6'd0;
        end else begin
            if (w_push) begin
                r_q_mem[r_q_wr_ptr] <= bus.inData;
                r_q_wr_ptr          <= r_q_wr_ptr + 5'd1;
            end
            if (w_pop) begin
                r_q_rd_ptr <= r_q_rd_ptr + 5'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + 6'd1;
                2'b01:   r_q_count <= r_q_count - 6'd1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // Temporary register file: full write has priority over the [33:1] update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAG; i++) begin
                r_rft[i] <= {RFT_W{1'b0}};
            end
        end else if (bus.New_entry) begin
            r_rft[bus.Waddr] <= bus.Data_In;
        end else if (bus.Update_entry) begin
            r_rft[bus.Waddr][33:1] <= bus.Data_In[33:1];
        end
    end

    assign bus.Rstag_rst   = r_rst_tag[bus.Rsaddr_rst];
    assign bus.Rsvalid_rst = r_rst_valid[bus.Rsaddr_rst];
    assign bus.Rttag_rst   = r_rst_tag[bus.Rtaddr_rst];
    assign bus.Rtvalid_rst = r_rst_valid[bus.Rtaddr_rst];
    assign bus.Wen1_rst    = w_wen1;
    assign bus.outData     = w_empty ? 5'd0 : r_q_mem[r_q_rd_ptr];
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.Data_out1   = r_rft[bus.Rd_Addr1];
    assign bus.Data_out2   = r_rft[bus.Rd_Addr2];

endmodule

// File: tb/tb_rob_state_core.sv
// Directed bench for rob_state_core: RST rename/retire/flush, order queue
// fill/drain across pointer wrap, and RFT write/update priority.
module tb_rob_state_core;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    rob_state_core_if bus ();

    rob_state_core dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] qval(input int k);
        logic [4:0] v;
        v = 5'(k + 10);
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.Rsaddr_rst = 5'd3;  bus.Rtaddr_rst = 5'd0;
        bus.Wdata_rst = 5'd0;   bus.Waddr_rst = 5'd0;
        bus.Wen_rst = 1'b0;     bus.Wen0_rst = 1'b0;
        bus.RB_tag_rst = 5'd0;  bus.RB_valid_rst = 1'b0;
        bus.inData = 5'd0;      bus.new_data = 1'b0;
        bus.out_data = 1'b0;    bus.increment = 1'b0;
        bus.Data_In = 73'd0;    bus.Waddr = 5'd0;
        bus.New_entry = 1'b0;   bus.Update_entry = 1'b0;
        bus.Rd_Addr1 = 5'd3;    bus.Rd_Addr2 = 5'd0;
        #3;
        chk("rst_rsvalid", {72'd0, bus.Rsvalid_rst}, 73'd0);
        chk("rst_dout1",   bus.Data_out1, 73'd0);
        chk("rst_empty",   {72'd0, bus.empty}, 73'd1);
        chk("rst_full",    {72'd0, bus.full}, 73'd0);
        chk("rst_outdata", {68'd0, bus.outData}, 73'd0);
        chk("rst_wen1",    {41'd0, bus.Wen1_rst}, 73'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // RST rename, visible only after the edge
        bus.Waddr_rst = 5'd5; bus.Wdata_rst = 5'd9; bus.Wen_rst = 1'b1; bus.Rsaddr_rst = 5'd5;
        #1;
        chk("wen1_decode", {41'd0, bus.Wen1_rst}, 73'h0_0000_0020);
        chk("rst_no_bypass", {72'd0, bus.Rsvalid_rst}, 73'd0);
        tick();
        bus.Wen_rst = 1'b0; bus.Rtaddr_rst = 5'd5;
        #1;
        chk("rs_tag", {68'd0, bus.Rstag_rst}, 73'd9);
        chk("rs_valid", {72'd0, bus.Rsvalid_rst}, 73'd1);
        chk("rt_tag", {68'd0, bus.Rttag_rst}, 73'd9);
        chk("rt_valid", {72'd0, bus.Rtvalid_rst}, 73'd1);

        bus.RB_tag_rst = 5'd9; bus.RB_valid_rst = 1'b1;
        tick();
        bus.RB_valid_rst = 1'b0;
        #1;
        chk("retire_clear", {72'd0, bus.Rsvalid_rst}, 73'd0);

        // re-map reg5->9, then retire 9 while renaming reg5->12: write wins
        bus.Wdata_rst = 5'd9; bus.Wen_rst = 1'b1;
        tick();
        bus.Wdata_rst = 5'd12; bus.RB_tag_rst = 5'd9; bus.RB_valid_rst = 1'b1;
        tick();
        bus.Wen_rst = 1'b0; bus.RB_valid_rst = 1'b0;
        #1;
        chk("wr_wins_tag", {68'd0, bus.Rstag_rst}, 73'd12);
        chk("wr_wins_valid", {72'd0, bus.Rsvalid_rst}, 73'd1);

        // retire clears only entries whose tag matches
        bus.Waddr_rst = 5'd7; bus.Wdata_rst = 5'd3; bus.Wen_rst = 1'b1;
        tick();
        bus.Waddr_rst = 5'd8; bus.Wdata_rst = 5'd4;
        tick();
        bus.Wen_rst = 1'b0; bus.RB_tag_rst = 5'd3; bus.RB_valid_rst = 1'b1;
        tick();
        bus.RB_valid_rst = 1'b0; bus.Rsaddr_rst = 5'd7; bus.Rtaddr_rst = 5'd8;
        #1;
        chk("retire_match", {72'd0, bus.Rsvalid_rst}, 73'd0);
        chk("retire_other", {72'd0, bus.Rtvalid_rst}, 73'd1);

        // flush beats a same-cycle rename
        bus.Rsaddr_rst = 5'd5; bus.Wen0_rst = 1'b1;
        bus.Waddr_rst = 5'd9; bus.Wdata_rst = 5'd1; bus.Wen_rst = 1'b1;
        tick();
        bus.Wen0_rst = 1'b0; bus.Wen_rst = 1'b0;
        #1;
        chk("flush_rs", {72'd0, bus.Rsvalid_rst}, 73'd0);
        chk("flush_rt", {72'd0, bus.Rtvalid_rst}, 73'd0);
        bus.Rsaddr_rst = 5'd9;
        #1;
        chk("flush_beats_wr", {72'd0, bus.Rsvalid_rst}, 73'd0);

        // queue basics: push 1,2,3, stall pop without increment
        bus.new_data = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.inData = 5'(i);
            tick();
        end
        bus.new_data = 1'b0;
        #1;
        chk("q_head1", {68'd0, bus.outData}, 73'd1);
        chk("q_not_empty", {72'd0, bus.empty}, 73'd0);
        bus.out_data = 1'b1; bus.increment = 1'b0;
        tick();
        chk("q_hold", {68'd0, bus.outData}, 73'd1);
        bus.increment = 1'b1;
        tick();
        chk("q_head2", {68'd0, bus.outData}, 73'd2);
        // push+pop together keeps count: queue becomes {3,20}
        bus.new_data = 1'b1; bus.inData = 5'd20;
        tick();
        bus.new_data = 1'b0;
        chk("q_head3", {68'd0, bus.outData}, 73'd3);
        tick();
        chk("q_head20", {68'd0, bus.outData}, 73'd20);
        tick();
        chk("q_drained", {72'd0, bus.empty}, 73'd1);
        chk("q_empty_out", {68'd0, bus.outData}, 73'd0);
        tick();
        chk("q_pop_empty", {72'd0, bus.empty}, 73'd1);
        bus.out_data = 1'b0; bus.increment = 1'b0;

        // fill to full (pointers start at 4, so this wraps)
        bus.new_data = 1'b1;
        for (int k = 0; k < 32; k++) begin
            bus.inData = qval(k);
            tick();
        end
        chk("q_full", {72'd0, bus.full}, 73'd1);
        chk("q_full_head", {68'd0, bus.outData}, {68'd0, qval(0)});
        // push while full with a pop: push dropped, count drops to 31
        bus.inData = 5'd31; bus.out_data = 1'b1; bus.increment = 1'b1;
        tick();
        bus.new_data = 1'b0;
        chk("q_drop_full", {72'd0, bus.full}, 73'd0);
        for (int k = 1; k < 32; k++) begin
            chk("q_drain", {68'd0, bus.outData}, {68'd0, qval(k)});
            tick();
        end
        chk("q_final_empty", {72'd0, bus.empty}, 73'd1);
        chk("q_final_out", {68'd0, bus.outData}, 73'd0);
        bus.out_data = 1'b0; bus.increment = 1'b0;

        // RFT full write, no bypass before the edge
        bus.Waddr = 5'd4; bus.Rd_Addr1 = 5'd4;
        bus.Data_In = {5'd7, 32'h400, 2'b00, 32'h0, 1'b0, 1'b1};
        bus.New_entry = 1'b1;
        #1;
        chk("rft_no_bypass", bus.Data_out1, 73'd0);
        tick();
        bus.New_entry = 1'b0;
        chk("rft_new", bus.Data_out1, {5'd7, 32'h400, 2'b00, 32'h0, 1'b0, 1'b1});
        bus.Data_In = {5'd0, 32'h0, 2'b11, 32'hDEAD, 1'b1, 1'b0};
        bus.Update_entry = 1'b1;
        tick();
        bus.Update_entry = 1'b0;
        chk("rft_update", bus.Data_out1, {5'd7, 32'h400, 2'b00, 32'hDEAD, 1'b1, 1'b1});
        bus.Waddr = 5'd6; bus.Rd_Addr2 = 5'd6;
        bus.Data_In = {5'd3, 32'h1234, 2'b10, 32'hBEEF, 1'b1, 1'b0};
        bus.New_entry = 1'b1; bus.Update_entry = 1'b1;
        tick();
        bus.New_entry = 1'b0; bus.Update_entry = 1'b0;
        chk("rft_new_prio", bus.Data_out2, {5'd3, 32'h1234, 2'b10, 32'hBEEF, 1'b1, 1'b0});
        chk("rft_other_kept", bus.Data_out1, {5'd7, 32'h400, 2'b00, 32'hDEAD, 1'b1, 1'b1});

        // async reset mid-operation
        bus.new_data = 1'b1; bus.inData = 5'd17;
        tick();
        bus.new_data = 1'b0;
        chk("pre_reset_head", {68'd0, bus.outData}, 73'd17);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_empty", {72'd0, bus.empty}, 73'd1);
        chk("areset_rft", bus.Data_out1, 73'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob_state_core.md
Name: rob_state_core

Overview:
- Storage core of the reorder buffer (ROB). Combines three functions with shared clock/reset:
  - register status table (RST): architectural reg -> in-flight tag;
  - 32-deep order queue of tags in program order;
  - 32-entry temporary register file (RFT) of 73-bit speculative entries indexed by tag.
- The ROB control FSM drives all ports; this block holds no control policy beyond what is stated here.

Parameters:
- NREG, 32, architectural registers / RST entries
- NTAG, 32, tags = RFT entries = order-queue depth
- RFT_W, 73, RFT entry width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Rsaddr_rst  in  5  RST read port A register
- Rstag_rst  out  5  tag mapped to Rsaddr_rst
- Rsvalid_rst  out  1  mapping valid
- Rtaddr_rst  in  5  RST read port B register
- Rttag_rst  out  5  tag for Rtaddr_rst
- Rtvalid_rst  out  1  mapping valid
- Wdata_rst  in  5  new tag to record
- Waddr_rst  in  5  register being renamed
- Wen_rst  in  1  RST write enable
- Wen0_rst  in  1  RST flush (clear all valid bits)
- Wen1_rst  out  32  one-hot decoded write enable
- RB_tag_rst  in  5  retiring tag
- RB_valid_rst  in  1  retire strobe
- inData  in  5  tag to enqueue
- new_data  in  1  enqueue request
- out_data  in  1  dequeue request
- increment  in  1  dequeue qualifier
- outData  out  5  head tag
- full  out  1  queue holds 32 tags
- empty  out  1  queue holds 0 tags
- Data_In  in  73  RFT entry {rd_reg[72:68], pc[67:36], type[35:34], spec_data[33:2], spec_valid[1], valid[0]}
- Waddr  in  5  RFT write index (tag)
- New_entry  in  1  write full 73-bit entry
- Update_entry  in  1  write bits [33:1] only
- Rd_Addr1  in  5  RFT read index 1
- Data_out1  out  73  entry at Rd_Addr1
- Rd_Addr2  in  5  RFT read index 2
- Data_out2  out  73  entry at Rd_Addr2

Behaviour:
- Reset (async): all RST entries {tag=0, valid=0}; queue pointers and count = 0 (empty=1, full=0); all RFT entries = 0. All read outputs therefore read 0. Reset mid-operation discards all state immediately.
- All reads are combinational from current state. No write-to-read bypass: a write becomes visible the cycle after the clock edge.
- RST, per rising edge, in priority order:
  1. Wen0_rst=1 clears every valid bit.
  2. Else Wen_rst=1 writes entry[Waddr_rst] = {Wdata_rst, 1}.
  3. RB_valid_rst=1 clears valid of every entry whose valid=1 and tag==RB_tag_rst. If that entry is also being written this cycle, the write wins.
- Wen1_rst = Wen_rst ? (1 << Waddr_rst) : 0. Combinational.
- Order queue: circular buffer, 32x5, read and write pointers plus 6-bit count.
  - push = new_data & !full: mem[wr_ptr] <= inData, wr_ptr+1 mod 32.
  - pop = out_data & increment & !empty: rd_ptr+1 mod 32.
  - Push and pop in the same cycle: count unchanged.
  - Push while full is dropped even if a pop occurs that cycle. Pop while empty is ignored.
  - outData = mem[rd_ptr] when !empty, else 0.
  - Pointers wrap 31 -> 0.
- RFT, per rising edge:
  - New_entry=1 writes entry[Waddr] = Data_In, with priority over Update_entry.
  - Else Update_entry=1 writes entry[Waddr][33:1] = Data_In[33:1]; bits [72:34] and [0] are kept.

Test Plan:
- Reset, then read Rsaddr_rst=3 and Rd_Addr1=3 -> Rsvalid_rst=0, Data_out1=0, empty=1, full=0, outData=0, Wen1_rst=0.
- RST write Waddr_rst=5, Wdata_rst=9, Wen_rst=1 -> Wen1_rst=0x00000020 in the same cycle; next cycle Rsaddr_rst=5 gives Rstag_rst=9, Rsvalid_rst=1. Then RB_valid_rst=1, RB_tag_rst=9 -> valid=0 next cycle. Repeat with a same-cycle write of tag 12 to reg 5 -> valid=1, tag=12.
- Push tags 1,2,3 -> outData=1. out_data=1, increment=0 -> outData stays 1. With increment=1 -> outData=2, then 3.
- Push 32 tags -> full=1; a 33rd push is dropped. Pop 32 -> empty=1, outData=0. Repeat across pointer wrap.
- RFT New_entry at Waddr=4, Data_In={5'd7, 32'h400, 2'b00, 32'h0, 1'b0, 1'b1} -> Data_out1 at Rd_Addr1=4 matches. Update_entry with spec_data=32'hDEAD, spec_valid=1 -> rd_reg=7, pc=0x400, valid=1 kept; [33:2]=0xDEAD, [1]=1.
- New_entry and Update_entry both asserted for Waddr=6 -> the full Data_In is stored. Flush via Wen0_rst -> all Rs/Rt valid outputs = 0.
